// File: rtl/fixed_power_calc_if.sv
// Handshake bundle between the fixed-point converters, the power
// calculator and the next processing stage.
interface fixed_power_calc_if #(
  parameter int W = 32
);
  logic         ACK_I;
  logic         ACK_V;
  logic [W-1:0] RESULT_I;
  logic [W-1:0] RESULT_V;
  logic [W-1:0] RESULT_P;
  logic         ACK_P;
  logic         BUSY;
  logic         OVF;
  logic         DROP;

  modport master (
    output ACK_I, ACK_V, RESULT_I, RESULT_V,
    input  RESULT_P, ACK_P, BUSY, OVF, DROP
  );

  modport slave (
    input  ACK_I, ACK_V, RESULT_I, RESULT_V,
    output RESULT_P, ACK_P, BUSY, OVF, DROP
  );
endinterface

// File: rtl/fixed_power_calc.sv
// P = I*V in a common Q format via a W-cycle shift-add multiplier.
// Define FIXED_POWER_SAT_EN to saturate out-of-range results and flag OVF.
module fixed_power_calc #(
  parameter int W    = 32,
  parameter int FRAC = 20
) (
  input  logic               CLK,
  input  logic               RST,
  fixed_power_calc_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    NORM
  } state_t;

  localparam logic [5:0]     LAST = 6'(W - 1);
  localparam logic [W-1:0]   ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE2 = {{(2*W-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic           ack_i_q, ack_v_q;
  logic [W-1:0]   i_q, i_d;
  logic [W-1:0]   v_q, v_d;
  logic           have_i_q, have_i_d;
  logic           have_v_q, have_v_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic [W-1:0]   res_q, res_d;
  logic           ackp_q, ackp_d;
  logic           drop_q, drop_d;

  logic           edge_i, edge_v;
  logic [W-1:0]   i_nxt, v_nxt;
  logic [2*W-1:0] shifted;
  logic [2*W-1:0] signed_res;
  logic [W-1:0]   norm_val;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + ONE) : x;
  endfunction

  assign edge_i = bus.ACK_I & ~ack_i_q;
  assign edge_v = bus.ACK_V & ~ack_v_q;
  assign i_nxt  = edge_i ? bus.RESULT_I : i_q;
  assign v_nxt  = edge_v ? bus.RESULT_V : v_q;

  // Truncate the magnitude first so negative results round toward zero.
  assign shifted    = acc_q >> FRAC;
  assign signed_res = sign_q ? (~shifted + ONE2) : shifted;

`ifdef FIXED_POWER_SAT_EN
  localparam logic [2*W-1:0] LIM_P =
    {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] LIM_N =
    {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]   SAT_P = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   SAT_N = {1'b1, {(W-1){1'b0}}};

  logic ovf_q, ovf_d;
  logic ovf_pos, ovf_neg;

  assign ovf_pos = ~sign_q & (shifted > LIM_P);
  assign ovf_neg = sign_q & (shifted > LIM_N);

  always_comb begin
    norm_val = signed_res[W-1:0];
    unique case (1'b1)
      ovf_pos: norm_val = SAT_P;
      ovf_neg: norm_val = SAT_N;
      default: norm_val = signed_res[W-1:0];
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == NORM) begin
      ovf_d = ovf_pos | ovf_neg;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.OVF = ovf_q;
`else
  assign norm_val = signed_res[W-1:0];
  assign bus.OVF  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    v_d      = v_q;
    have_i_d = have_i_q;
    have_v_d = have_v_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    res_d    = res_q;
    ackp_d   = 1'b0;
    drop_d   = drop_q;

    unique case (state_q)
      IDLE: begin
        if (edge_i) begin
          i_d      = bus.RESULT_I;
          have_i_d = 1'b1;
        end
        if (edge_v) begin
          v_d      = bus.RESULT_V;
          have_v_d = 1'b1;
        end
        if ((have_i_q | edge_i) &&
            (have_v_q | edge_v)) begin
          have_i_d = 1'b0;
          have_v_d = 1'b0;
          mcand_d  = {{W{1'b0}}, mag(i_nxt)};
          mplier_d = mag(v_nxt);
          acc_d    = '0;
          cnt_d    = '0;
          sign_d   = i_nxt[W-1] ^ v_nxt[W-1];
          state_d  = MULT;
        end
      end
      MULT: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == LAST) begin
          state_d = NORM;
        end
      end
      NORM: begin
        res_d   = norm_val;
        ackp_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Edges seen mid-computation are lost; remember that it happened.
    if (state_q != IDLE && (edge_i || edge_v)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ack_i_q  <= 1'b0;
      ack_v_q  <= 1'b0;
      i_q      <= '0;
      v_q      <= '0;
      have_i_q <= 1'b0;
      have_v_q <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      res_q    <= '0;
      ackp_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_i_q  <= bus.ACK_I;
      ack_v_q  <= bus.ACK_V;
      i_q      <= i_d;
      v_q      <= v_d;
      have_i_q <= have_i_d;
      have_v_q <= have_v_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      res_q    <= res_d;
      ackp_q   <= ackp_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.RESULT_P = res_q;
  assign bus.ACK_P    = ackp_q;
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.DROP     = drop_q;

endmodule

// File: tb/tb_fixed_power_calc.sv
// Scoreboard bench for fixed_power_calc: directed vectors,
// expected results queued at issue and checked on ACK_P.
module tb_fixed_power_calc;

  localparam int LAT = 33;

  typedef struct {
    logic [31:0] p;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   ackp_cnt;
  int   base;
  exp_t sb[$];

  fixed_power_calc_if #(.W(32)) bus ();

  fixed_power_calc #(
    .W    (32),
    .FRAC (20)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total = total + 1;
    if (a !== e) begin
      bad = bad + 1;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ACK_P === 1'b1) begin
      ackp_cnt = ackp_cnt + 1;
      if (sb.size() == 0) begin
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL unexpected_ack_p got=%h want=none",
                 bus.RESULT_P);
      end else begin
        e = sb.pop_front();
        chk("result_p", bus.RESULT_P, e.p);
        chk("ovf", {31'd0, bus.OVF}, {31'd0, e.ovf});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic pulse(input bit          di,
                       input bit          dv,
                       input logic [31:0] xi,
                       input logic [31:0] xv,
                       input bit          push,
                       input logic [31:0] p,
                       input logic        ovf);
    exp_t e;
    @(negedge clk);
    if (di) begin
      bus.RESULT_I = xi;
      bus.ACK_I    = 1'b1;
    end
    if (dv) begin
      bus.RESULT_V = xv;
      bus.ACK_V    = 1'b1;
    end
    if (push) begin
      e.p   = p;
      e.ovf = ovf;
      e.cyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.ACK_I = 1'b0;
    bus.ACK_V = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int n = 0; n < bound && sb.size() != 0; n++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL timeout got=%0d want=0 pending",
               sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    total        = 0;
    bad          = 0;
    ackp_cnt     = 0;
    rst          = 1'b1;
    bus.ACK_I    = 1'b0;
    bus.ACK_V    = 1'b0;
    bus.RESULT_I = '0;
    bus.RESULT_V = '0;
    repeat (3) @(negedge clk);
    chk("rst_result_p", bus.RESULT_P, 32'h0);
    chk("rst_ack_p", {31'd0, bus.ACK_P}, 32'h0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'h0);
    chk("rst_ovf", {31'd0, bus.OVF}, 32'h0);
    chk("rst_drop", {31'd0, bus.DROP}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1.5 * 2.0, V arrives later
    pulse(1, 0, 32'h0018_0000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    pulse(0, 1, 0, 32'h0020_0000, 1, 32'h0030_0000, 0);
    chk("busy_mult", {31'd0, bus.BUSY}, 32'h1);
    wait_done(60);

    // -1.0 * 0.5, same cycle
    base = ackp_cnt;
    pulse(1, 1, 32'hFFF0_0000, 32'h0008_0000,
          1, 32'hFFF8_0000, 0);
    wait_done(60);
    chk("one_pulse", ackp_cnt - base, 1);

    // max * max
`ifdef FIXED_POWER_SAT_EN
    pulse(1, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
          1, 32'h7FFF_FFFF, 1);
`else
    pulse(1, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
          1, 32'hFFFF_F000, 0);
`endif
    wait_done(60);

    // latest I wins
    pulse(1, 0, 32'h0010_0000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    pulse(1, 0, 32'h0030_0000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    pulse(0, 1, 0, 32'h0010_0000, 1, 32'h0030_0000, 0);
    wait_done(60);

    // edge while busy is dropped
    base = ackp_cnt;
    chk("drop_before", {31'd0, bus.DROP}, 32'h0);
    pulse(1, 1, 32'h0020_0000, 32'h0004_0000,
          1, 32'h0008_0000, 0);
    repeat (5) @(negedge clk);
    pulse(0, 1, 0, 32'h7FFF_FFFF, 0, 0, 0);
    chk("drop_set", {31'd0, bus.DROP}, 32'h1);
    wait_done(60);
    repeat (40) @(negedge clk);
    chk("drop_pulses", ackp_cnt - base, 1);

    // level ACKs held 100 cycles
    base = ackp_cnt;
    @(negedge clk);
    bus.RESULT_I = 32'h0028_0000;
    bus.RESULT_V = 32'hFFE0_0000;
    bus.ACK_I    = 1'b1;
    bus.ACK_V    = 1'b1;
    e.p   = 32'hFFB0_0000;
    e.ovf = 1'b0;
    e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    repeat (100) @(negedge clk);
    bus.ACK_I = 1'b0;
    bus.ACK_V = 1'b0;
    wait_done(60);
    repeat (5) @(negedge clk);
    chk("held_pulses", ackp_cnt - base, 1);

    // reset mid-multiply
    base = ackp_cnt;
    pulse(1, 1, 32'h0010_0000, 32'h0010_0000, 0, 0, 0);
    repeat (9) @(negedge clk);
    chk("busy_pre_rst", {31'd0, bus.BUSY}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_result_p", bus.RESULT_P, 32'h0);
    chk("mid_rst_ack_p", {31'd0, bus.ACK_P}, 32'h0);
    chk("mid_rst_busy", {31'd0, bus.BUSY}, 32'h0);
    chk("mid_rst_ovf", {31'd0, bus.OVF}, 32'h0);
    chk("mid_rst_drop", {31'd0, bus.DROP}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    chk("rst_no_pulse", ackp_cnt - base, 0);

    pulse(1, 1, 32'h0010_0000, 32'h0010_0000,
          1, 32'h0010_0000, 0);
    wait_done(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
